ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 64×8 single-port RAM. The RAM has an asynchronous read and a write on the rising clock edge. The arbiter owns the RAM's address, data-in and write-enable pins, and serialises read/write transactions from ports A and B using a req/ack handshake. It optionally sweeps the RAM to zero after reset before it accepts traffic.

## Interface
Parameters:
- DATA_W, 8, data width of RAM and ports
- ADDR_W, 6, requester address width (64 words)
- RAM_ADDR_W, 8, RAM address pin width; upper bits driven 0

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_a / req_b  in  1  transaction request, held until ack
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  word address
- wdata_a / wdata_b  in  DATA_W  write data
- ack_a / ack_b  out  1  one-cycle completion pulse
- rdata_a / rdata_b  out  DATA_W  read result, valid from ack, held until next ack on that port
- busy  out  1  high while in BOOT or INIT (no requests accepted)
- ram_addr  out  RAM_ADDR_W  to RAM address_in
- ram_din  out  DATA_W  to RAM data_in
- ram_we  out  1  to RAM write_enable
- ram_dout  in  DATA_W  from RAM data_out (combinational)

## Operation
- FSM states:
  - BOOT: reset state, one cycle, ram_we = 0.
  - INIT: macro only.
  - IDLE
  - ACCESS
- BOOT -> INIT (macro) or IDLE.
- IDLE:
  - A port is eligible when req_x = 1 and ack_x = 0. A port whose ack is high this cycle is never re-granted on its stale request.
  - One eligible port: grant it.
  - Both eligible: grant the port not in last_grant.
  - last_grant resets to B, so A wins the first tie.
  - On grant, latch the port's addr/we/wdata, set gnt_id, update last_grant, go to ACCESS.
- ACCESS (one cycle):
  - ram_addr = {0, lat_addr}, ram_din = lat_wdata, ram_we = lat_we.
  - At the end-of-cycle edge: if read, rdata_gnt <= ram_dout; ack_gnt <= 1. Then go to IDLE.
  - On a write, rdata_x is unchanged.
- Outside ACCESS/INIT: ram_we = 0, ram_addr = 0, ram_din = 0.
- The RAM interface outputs are combinational decodes of registered state only.
- Reset value of every register and output: ack 0, rdata 0, ram_we 0, ram_addr 0, ram_din 0, state BOOT, busy 1.
- Reset mid-operation: all state is cleared immediately. An in-flight ACCESS write is not performed (its edge never occurs in ACCESS) and no ack is issued. With the macro compiled in, INIT restarts from address 0.

## Timing
- A request sampled in IDLE at edge k is serviced in the ACCESS cycle k..k+1. ack is high in cycle k+1..k+2 together with valid rdata.
- Single-port service period: 3 cycles (request, ACCESS, ack cycle). The ack cycle is IDLE, where the other port may be granted.
- Peak throughput with both ports requesting: one transaction per 2 cycles, alternating A/B.
- ack is a single-cycle pulse. The requester must drop req or change fields in the ack cycle to avoid a repeat.
- Requester fields need be stable only at the IDLE grant edge; they are latched there.

## Configuration
- RAM_ARB_INIT_CLEAR_EN defined:
  - BOOT -> INIT.
  - A 6-bit counter sweeps addresses 0..63 with ram_we = 1 and ram_din = 0, one word per cycle (64 cycles), then goes to IDLE.
  - busy is high in BOOT and INIT. req is ignored and no ack is issued until IDLE.
- Not defined:
  - BOOT -> IDLE.
  - RAM keeps its power-up contents (word i = 2i).
  - busy is high only in BOOT.

## Structure
- Package ram_arb_pkg:
  - state enum (BOOT, INIT, IDLE, ACCESS)
  - DEPTH = 64
  - default widths
  - port-id encoding (A = 0, B = 1)
- Sub-module rr_pick2: combinational 2-way round-robin picker. Inputs: eligible[1:0] and last_grant. Outputs: grant_valid and grant_id.

## Test plan
- Reset release, macro off: busy falls after 1 cycle. A reads addr 5 -> ack_a 2 edges after request sample, rdata_a = 10.
- A writes 0x3C to addr 7, then B reads addr 7 -> rdata_b = 0x3C. No ack on A during B's transaction.
- req_a and req_b held continuously with reads of addr 1 and addr 2 -> grants A, B, A, B. ack every 2 cycles, alternating. rdata_a = 2, rdata_b = 4.
- Macro on: after reset, busy high for 65 cycles and ram_we high for 64 of them. req_a asserted during INIT gets no ack until IDLE. Subsequent read of addr 63 -> 0.
- rst_n pulsed low during an ACCESS write of 0xFF to addr 9 -> ack never asserted, all outputs 0. Later read of addr 9 returns 18 (macro off).

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// The RAM_ARB_INIT_CLEAR_EN build option is consumed in ram_arbiter.sv.
package ram_arb_pkg;

  localparam int DEPTH            = 64;
  localparam int DATA_W_DEF       = 8;
  localparam int ADDR_W_DEF       = 6;
  localparam int RAM_ADDR_W_DEF   = 8;
  localparam int INIT_CNT_W       = $clog2(DEPTH);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    INIT   = 2'd1,
    IDLE   = 2'd2,
    ACCESS = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// win last time is chosen.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |eligible;
    grant_id    = PORT_A;
    if (eligible == 2'b11) begin
      grant_id = ~last_grant;
    end else if (eligible[1]) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for a 64x8 single-port RAM serving ports A and B.
// Define RAM_ARB_INIT_CLEAR_EN to zero the RAM after reset before serving traffic.
//
// state  | meaning
// BOOT   | first cycle after reset, RAM idle
// INIT   | clearing sweep, one word per cycle (build option only)
// IDLE   | waiting for an eligible request, grant on the edge
// ACCESS | latched transaction drives the RAM for one cycle
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     wdata_a,
  input  logic [DATA_W-1:0]     wdata_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b,
  output logic                  busy,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  output logic                  ram_we,
  input  logic [DATA_W-1:0]     ram_dout
);

  arb_state_e        state_q, state_d;
  logic              last_grant;
  logic              gnt_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              grant_valid;
  logic              grant_id;
  logic              init_done;

  // A port acked this cycle still shows its stale request; mask it out.
  rr_pick2 u_pick (
    .eligible    ({req_b & ~ack_b, req_a & ~ack_a}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef RAM_ARB_INIT_CLEAR_EN
  // Down-counter; the sweep address is its complement so words go 0..63.
  logic [INIT_CNT_W-1:0] init_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '1;
    end else if (state_q == INIT) begin
      init_cnt <= init_cnt - 1'b1;
    end
  end

  assign init_done = (init_cnt == '0);
`else
  assign init_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef RAM_ARB_INIT_CLEAR_EN
      BOOT:    state_d = INIT;
`else
      BOOT:    state_d = IDLE;
`endif
      INIT:    if (init_done) state_d = IDLE;
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      last_grant <= PORT_B;
      gnt_id     <= PORT_A;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
    end else begin
      state_q <= state_d;
      ack_a   <= (state_q == ACCESS) && (gnt_id == PORT_A);
      ack_b   <= (state_q == ACCESS) && (gnt_id == PORT_B);
      if (state_q == IDLE && grant_valid) begin
        gnt_id     <= grant_id;
        last_grant <= grant_id;
        lat_addr   <= (grant_id == PORT_B) ? addr_b  : addr_a;
        lat_we     <= (grant_id == PORT_B) ? we_b    : we_a;
        lat_wdata  <= (grant_id == PORT_B) ? wdata_b : wdata_a;
      end
      if (state_q == ACCESS && !lat_we) begin
        if (gnt_id == PORT_B) rdata_b <= ram_dout;
        else                  rdata_a <= ram_dout;
      end
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (state_q == ACCESS) begin
      ram_addr = RAM_ADDR_W'(lat_addr);
      ram_din  = lat_wdata;
      ram_we   = lat_we;
    end
`ifdef RAM_ARB_INIT_CLEAR_EN
    if (state_q == INIT) begin
      ram_addr = RAM_ADDR_W'(~init_cnt);
      ram_we   = 1'b1;
    end
`endif
  end

  assign busy = (state_q == BOOT) || (state_q == INIT);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64x8 RAM (word i = 2i at power-up).
// Expected values follow the RAM_ARB_INIT_CLEAR_EN setting used for the build.
module tb_ram_arbiter;

`ifdef RAM_ARB_INIT_CLEAR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 0, req_b = 0, we_a = 0, we_b = 0;
  logic [5:0] addr_a = 0, addr_b = 0;
  logic [7:0] wdata_a = 0, wdata_b = 0;
  logic       ack_a, ack_b, busy, ram_we;
  logic [7:0] rdata_a, rdata_b, ram_addr, ram_din, ram_dout;
  logic [7:0] mem [64];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 8'(2 * i);
  always @(posedge clk) if (ram_we) mem[ram_addr[5:0]] <= ram_din;
  assign ram_dout = mem[ram_addr[5:0]];

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // Waits (bounded) for the ack of one port; lat = -1 on timeout.
  task automatic wait_ack(input bit port, output int lat, output bit other_seen);
    lat = -1;
    other_seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((port ? ack_a : ack_b) === 1'b1) other_seen = 1'b1;
      if ((port ? ack_b : ack_a) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int busy_cnt, we_cnt;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin n_bad++; $display("FAIL reset_ack got a=%b b=%b want 0 0", ack_a, ack_b); end
    n_cmp++; if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got a=%h b=%h want 00 00", rdata_a, rdata_b); end
    n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_din !== 8'h00) begin n_bad++; $display("FAIL reset_ram got we=%b addr=%h din=%h want 0 00 00", ram_we, ram_addr, ram_din); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", busy); end
    rst_n = 1'b1;
    #1;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    we_cnt   = (ram_we === 1'b1) ? 1 : 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (ram_we === 1'b1) we_cnt++;
    end
    n_cmp++; if (busy_cnt != (INIT_EN ? 65 : 1)) begin n_bad++; $display("FAIL boot_busy_cycles got %0d want %0d", busy_cnt, INIT_EN ? 65 : 1); end
    n_cmp++; if (we_cnt != (INIT_EN ? 64 : 0)) begin n_bad++; $display("FAIL boot_we_cycles got %0d want %0d", we_cnt, INIT_EN ? 64 : 0); end
  endtask

  task automatic test_read_a();
    logic [7:0] exp = INIT_EN ? 8'd0 : 8'd10;
    req_a = 1; we_a = 0; addr_a = 6'd5;
    @(negedge clk);
    n_cmp++; if (ram_addr !== 8'd5 || ram_we !== 1'b0 || ack_a !== 1'b0) begin n_bad++; $display("FAIL read_a_access got addr=%h we=%b ack=%b want 05 0 0", ram_addr, ram_we, ack_a); end
    @(negedge clk);
    n_cmp++; if (ack_a !== 1'b1 || rdata_a !== exp) begin n_bad++; $display("FAIL read_a_ack got ack=%b rdata=%h want 1 %h", ack_a, rdata_a, exp); end
    n_cmp++; if (ram_addr !== 8'h00 || ram_we !== 1'b0) begin n_bad++; $display("FAIL read_a_idle_ram got addr=%h we=%b want 00 0", ram_addr, ram_we); end
    req_a = 0;
    @(negedge clk);
    n_cmp++; if (ack_a !== 1'b0 || rdata_a !== exp) begin n_bad++; $display("FAIL read_a_hold got ack=%b rdata=%h want 0 %h", ack_a, rdata_a, exp); end
  endtask

  task automatic test_write_read();
    int lat; bit other;
    logic [7:0] prev_a = INIT_EN ? 8'd0 : 8'd10;
    req_a = 1; we_a = 1; addr_a = 6'd7; wdata_a = 8'h3C;
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 8'd7 || ram_din !== 8'h3C) begin n_bad++; $display("FAIL write_a_ram got we=%b addr=%h din=%h want 1 07 3c", ram_we, ram_addr, ram_din); end
    @(negedge clk);
    n_cmp++; if (ack_a !== 1'b1 || rdata_a !== prev_a) begin n_bad++; $display("FAIL write_a_ack got ack=%b rdata=%h want 1 %h", ack_a, rdata_a, prev_a); end
    req_a = 0; we_a = 0;
    req_b = 1; we_b = 0; addr_b = 6'd7;
    wait_ack(1'b1, lat, other);
    req_b = 0;
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL read_b_latency got %0d want 2", lat); end
    n_cmp++; if (rdata_b !== 8'h3C) begin n_bad++; $display("FAIL read_b_data got %h want 3c", rdata_b); end
    n_cmp++; if (other !== 1'b0) begin n_bad++; $display("FAIL read_b_no_ack_a got %b want 0", other); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ack [8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [7:0] exp_a = INIT_EN ? 8'd0 : 8'd2;
    logic [7:0] exp_b = INIT_EN ? 8'd0 : 8'd4;
    @(negedge clk);
    req_a = 1; we_a = 0; addr_a = 6'd1;
    req_b = 1; we_b = 0; addr_b = 6'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if ({ack_a, ack_b} !== exp_ack[i]) begin n_bad++; $display("FAIL b2b_ack cycle %0d got %b want %b", i, {ack_a, ack_b}, exp_ack[i]); end
    end
    req_a = 0; req_b = 0;
    n_cmp++; if (rdata_a !== exp_a || rdata_b !== exp_b) begin n_bad++; $display("FAIL b2b_rdata got a=%h b=%h want %h %h", rdata_a, rdata_b, exp_a, exp_b); end
    repeat (2) @(negedge clk);
    n_cmp++; if (ack_a !== 1'b0 || ack_b !== 1'b0) begin n_bad++; $display("FAIL b2b_quiet got a=%b b=%b want 0 0", ack_a, ack_b); end
  endtask

  task automatic test_reset_mid_write();
    int lat; bit other; bit seen; int waited;
    logic [7:0] exp9 = INIT_EN ? 8'd0 : 8'd18;
    seen = 0;
    req_a = 1; we_a = 1; addr_a = 6'd9; wdata_a = 8'hFF;
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 8'd9 || ram_din !== 8'hFF) begin n_bad++; $display("FAIL midrst_access got we=%b addr=%h din=%h want 1 09 ff", ram_we, ram_addr, ram_din); end
    rst_n = 0;
    #1;
    n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_din !== 8'h00 || busy !== 1'b1) begin n_bad++; $display("FAIL midrst_outputs got we=%b addr=%h din=%h busy=%b want 0 00 00 1", ram_we, ram_addr, ram_din, busy); end
    n_cmp++; if (ack_a !== 1'b0 || rdata_a !== 8'h00 || rdata_b !== 8'h00) begin n_bad++; $display("FAIL midrst_regs got ack=%b ra=%h rb=%h want 0 00 00", ack_a, rdata_a, rdata_b); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack_a === 1'b1) seen = 1;
    end
    req_a = 0; we_a = 0;
    rst_n = 1;
    waited = 0;
    while (busy !== 1'b0 && waited < 200) begin
      @(negedge clk);
      if (ack_a === 1'b1) seen = 1;
      waited++;
    end
    n_cmp++; if (seen !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_no_ack got ack_seen=%b busy=%b want 0 0", seen, busy); end
    req_a = 1; addr_a = 6'd9;
    wait_ack(1'b0, lat, other);
    req_a = 0;
    n_cmp++; if (lat != 2 || rdata_a !== exp9) begin n_bad++; $display("FAIL midrst_read9 got lat=%0d rdata=%h want 2 %h", lat, rdata_a, exp9); end
  endtask

`ifdef RAM_ARB_INIT_CLEAR_EN
  task automatic test_init_blocks_req();
    int lat; bit other; bit early;
    early = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    req_a = 1; we_a = 0; addr_a = 6'd63;
    rst_n = 1;
    for (int i = 0; i < 200 && busy !== 1'b0; i++) begin
      @(negedge clk);
      if (ack_a === 1'b1) early = 1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL init_ack_blocked got %b want 0", early); end
    wait_ack(1'b0, lat, other);
    req_a = 0;
    n_cmp++; if (lat != 2 || rdata_a !== 8'h00) begin n_bad++; $display("FAIL init_read63 got lat=%0d rdata=%h want 2 00", lat, rdata_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_a();
    test_write_read();
    test_back_to_back();
    test_reset_mid_write();
`ifdef RAM_ARB_INIT_CLEAR_EN
    test_init_blocks_req();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
